// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, long-latency results
// queue in a small FIFO and drain in free slots or via a forced stall. Optional: WB_ARB_PERF_CNT_EN.
module wb_port_arbiter #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_pipe_result,
    input  logic [REG_ADDR_W-1:0] i_pipe_rd_addr,
    input  logic                  i_pipe_reg_we,
    input  logic                  i_llu_valid,
    input  logic [DATA_WIDTH-1:0] i_llu_data,
    input  logic [REG_ADDR_W-1:0] i_llu_rd_addr,
    output logic                  o_llu_ready,
    output logic                  o_stall_pipe,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic                  o_reg_we,
    output logic                  o_llu_pending
`ifdef WB_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           o_conflict_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SRV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [SRV_W-1:0] SRV_ONE     = SRV_W'(1);
    localparam logic [SRV_W-1:0] SRV_LIMIT   = SRV_W'(STARVE_LIMIT);
    localparam logic [SRV_W-1:0] SRV_LAST    = SRV_W'(STARVE_LIMIT - 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_stall;
    logic [SRV_W-1:0]      r_starve_cnt;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [REG_ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pipe_req;
    logic                  w_llu_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_pipe_grant;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_result;
    logic [REG_ADDR_W-1:0] w_rd_addr;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_FULL);
    assign w_pipe_req  = i_pipe_reg_we && (i_pipe_rd_addr != '0);
    assign w_llu_ready = !w_full && (r_state == ST_NORMAL);
    // x0 results are handshaken but never stored.
    assign w_push      = i_llu_valid && w_llu_ready && (i_llu_rd_addr != '0);

    always_comb begin
        w_pop        = 1'b0;
        w_pipe_grant = 1'b0;
        w_we         = 1'b0;
        w_result     = '0;
        w_rd_addr    = '0;
        if (r_state == ST_DRAIN) begin
            if (!w_empty) begin
                w_pop     = 1'b1;
                w_we      = 1'b1;
                w_result  = r_mem_data[r_rd_ptr];
                w_rd_addr = r_mem_addr[r_rd_ptr];
            end
        end else if (w_pipe_req) begin
            w_pipe_grant = 1'b1;
            w_we         = 1'b1;
            w_result     = i_pipe_result;
            w_rd_addr    = i_pipe_rd_addr;
        end else if (!w_empty) begin
            w_pop     = 1'b1;
            w_we      = 1'b1;
            w_result  = r_mem_data[r_rd_ptr];
            w_rd_addr = r_mem_addr[r_rd_ptr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= i_llu_data;
            r_mem_addr[r_wr_ptr] <= i_llu_rd_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_NORMAL;
            r_stall      <= 1'b0;
            r_starve_cnt <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            case (r_state)
                ST_NORMAL: begin
                    if (!w_empty && !w_pop) begin
                        // Enter DRAIN on the edge where the count lands on the limit.
                        if (r_starve_cnt >= SRV_LAST) begin
                            r_state <= ST_DRAIN;
                            r_stall <= 1'b1;
                        end
                        if (r_starve_cnt != SRV_LIMIT) r_starve_cnt <= r_starve_cnt + SRV_ONE;
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    r_starve_cnt <= '0;
                    if (w_empty || (r_count == CNT_ONE)) begin
                        r_state <= ST_NORMAL;
                        r_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_NORMAL;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_ARB_PERF_CNT_EN
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_conflict_cnt <= '0;
        end else if (w_pipe_grant && !w_empty && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign o_conflict_cnt = r_conflict_cnt;
`endif

    assign o_llu_ready   = w_llu_ready;
    assign o_stall_pipe  = r_stall;
    assign o_result      = w_result;
    assign o_rd_addr     = w_rd_addr;
    assign o_reg_we      = w_we;
    assign o_llu_pending = !w_empty;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: cycle-tagged write scoreboard plus directed
// handshake/stall checks.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic [63:0] pipe_result;
    logic [4:0]  pipe_rd;
    logic        pipe_we;
    logic        llu_valid;
    logic [63:0] llu_data;
    logic [4:0]  llu_rd;
    logic        llu_ready;
    logic        stall_pipe;
    logic [63:0] result;
    logic [4:0]  rd_addr;
    logic        reg_we;
    logic        llu_pending;
`ifdef WB_ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt;
`endif

    wb_port_arbiter #(
        .DATA_WIDTH  (64),
        .REG_ADDR_W  (5),
        .FIFO_DEPTH  (2),
        .STARVE_LIMIT(4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pipe_result (pipe_result),
        .i_pipe_rd_addr(pipe_rd),
        .i_pipe_reg_we (pipe_we),
        .i_llu_valid   (llu_valid),
        .i_llu_data    (llu_data),
        .i_llu_rd_addr (llu_rd),
        .o_llu_ready   (llu_ready),
        .o_stall_pipe  (stall_pipe),
        .o_result      (result),
        .o_rd_addr     (rd_addr),
        .o_reg_we      (reg_we),
        .o_llu_pending (llu_pending)
`ifdef WB_ARB_PERF_CNT_EN
        ,
        .o_conflict_cnt(conflict_cnt)
`endif
    );

    typedef struct {
        int unsigned cyc;
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         sb_e;
    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    bit          sb_on = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Keeps the queue ordered by the cycle in which each write must appear.
    task automatic expect_wr(input int unsigned dc, input logic [4:0] a, input logic [63:0] d);
        wr_t         e;
        int unsigned idx;
        e.cyc  = cyc + dc;
        e.addr = a;
        e.data = d;
        idx    = exp_q.size();
        while (idx > 0 && exp_q[idx-1].cyc > e.cyc) idx--;
        exp_q.insert(idx, e);
    endtask

    always @(negedge clk) begin
        if (sb_on) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                sb_e = exp_q.pop_front();
                check("wr_we",   64'(reg_we),  64'd1);
                check("wr_addr", 64'(rd_addr), 64'(sb_e.addr));
                check("wr_data", result,       sb_e.data);
            end else if (reg_we !== 1'b0) begin
                check("spurious_we", 64'(reg_we), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pwe, input logic [4:0] prd, input logic [63:0] pdat,
                         input logic lv, input logic [4:0] lrd, input logic [63:0] ldat);
        pipe_we     = pwe;
        pipe_rd     = prd;
        pipe_result = pdat;
        llu_valid   = lv;
        llu_rd      = lrd;
        llu_data    = ldat;
    endtask

    // Two LLU results queued behind five back-to-back pipeline writes; DRAIN follows.
    task automatic starve_seq(input logic [4:0] ra, input logic [63:0] da,
                              input logic [4:0] rb, input logic [63:0] db, input bit second_written);
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            drive(1'b1, 5'(10 + i), 64'hC0DE_0000 + 64'(i), (i < 2), (i == 0) ? ra : rb, (i == 0) ? da : db);
            expect_wr(0, 5'(10 + i), 64'hC0DE_0000 + 64'(i));
            if (i == 0) expect_wr(5, ra, da);
            if (i == 1 && second_written) expect_wr(5, rb, db);
            @(negedge clk);
            check("starve_nostall", 64'(stall_pipe), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        repeat (2) step();
        rst   = 1'b0;
        sb_on = 1'b1;
        @(negedge clk);
        check("rst_we",      64'(reg_we),      64'd0);
        check("rst_stall",   64'(stall_pipe),  64'd0);
        check("rst_ready",   64'(llu_ready),   64'd1);
        check("rst_pending", 64'(llu_pending), 64'd0);

        // Pipeline write with empty FIFO: zero latency.
        step();
        drive(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0);
        expect_wr(0, 5'd5, 64'hAA);
        @(negedge clk);
        check("pipe_pending", 64'(llu_pending), 64'd0);

        // Single LLU result, written the following cycle.
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h1234);
        expect_wr(1, 5'd7, 64'h1234);
        @(negedge clk);
        check("llu_ready", 64'(llu_ready), 64'd1);
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        check("llu_pend_n1", 64'(llu_pending), 64'd1);
        step();
        @(negedge clk);
        check("llu_pend_n2", 64'(llu_pending), 64'd0);

        // Starvation -> forced drain of rd3 then rd4.
        starve_seq(5'd3, 64'h33, 5'd4, 64'h44, 1'b1);
        for (int unsigned i = 0; i < 2; i++) begin
            step();
            drive(1'b1, 5'd13, 64'hDEAD, 1'b1, 5'd9, 64'h99);
            @(negedge clk);
            check("drain_stall", 64'(stall_pipe), 64'd1);
            check("drain_ready", 64'(llu_ready),  64'd0);
        end
        step();
        drive(1'b1, 5'd13, 64'hBEEF, 1'b0, 5'd0, 64'd0);
        expect_wr(0, 5'd13, 64'hBEEF);
        @(negedge clk);
        check("post_drain_stall",   64'(stall_pipe),  64'd0);
        check("post_drain_pending", 64'(llu_pending), 64'd0);

        // Fill FIFO behind pipeline writes, then hold i_llu_valid with the pipe idle.
        step();
        drive(1'b1, 5'd21, 64'h2100, 1'b1, 5'd24, 64'hA1);
        expect_wr(0, 5'd21, 64'h2100);
        expect_wr(2, 5'd24, 64'hA1);
        step();
        drive(1'b1, 5'd22, 64'h2200, 1'b1, 5'd25, 64'hA2);
        expect_wr(0, 5'd22, 64'h2200);
        expect_wr(2, 5'd25, 64'hA2);
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd26, 64'hA3);
        @(negedge clk);
        check("full_ready", 64'(llu_ready), 64'd0);
        step();
        expect_wr(1, 5'd26, 64'hA3);
        @(negedge clk);
        check("refill_ready", 64'(llu_ready), 64'd1);
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step();
        @(negedge clk);
        check("full_pending", 64'(llu_pending), 64'd0);

        // x0 on both requesters in the same cycle.
        step();
        drive(1'b1, 5'd0, 64'h5555, 1'b1, 5'd0, 64'h6666);
        @(negedge clk);
        check("x0_ready", 64'(llu_ready), 64'd1);
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        check("x0_pending", 64'(llu_pending), 64'd0);

        // Reset asserted during DRAIN drops the second buffered entry.
        starve_seq(5'd17, 64'h1717, 5'd18, 64'h1818, 1'b0);
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rstdrain_stall", 64'(stall_pipe), 64'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstdrain_stall_after", 64'(stall_pipe),  64'd0);
        check("rstdrain_ready",       64'(llu_ready),   64'd1);
        check("rstdrain_pending",     64'(llu_pending), 64'd0);
        step();
        step();
        @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
